// File: rtl/ex_stage_pkg.sv
// Shared types and encodings for the MIPS execute stage.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package ex_stage_pkg;

  localparam int ID_TO_EX_WD  = 147;
  localparam int EX_TO_MEM_WD = 76;
  localparam int EX_TO_ID_WD  = 38;
  localparam int STALL_WD     = 6;
  localparam int DIV_ITERS    = 32;

  // Stall vector positions and polarity
  localparam int   STALL_EX  = 2;
  localparam int   STALL_MEM = 3;
  localparam logic STOP      = 1'b1;
  localparam logic NO_STOP   = 1'b0;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLT  = 5'd2;
  localparam logic [4:0] ALU_SLTU = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_XOR  = 5'd6;
  localparam logic [4:0] ALU_NOR  = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;
  localparam logic [4:0] ALU_MFHI = 5'd12;
  localparam logic [4:0] ALU_MFLO = 5'd13;
  localparam logic [4:0] ALU_PASS = 5'd14;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [1:0] MEM_SIZE_BYTE = 2'b00;
  localparam logic [1:0] MEM_SIZE_HALF = 2'b01;
  localparam logic [1:0] MEM_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] store_data;
    logic        data_ram_en;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [2:0]  md_op;
  } id_to_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic        data_ram_en;
    logic [3:0]  data_ram_wen;
    logic        sel_rf_res;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] ex_result;
  } ex_to_mem_t;

  // Magnitude of a 32-bit operand; only signed operations take the absolute value
  function automatic logic [31:0] mag32(input logic [31:0] x, input logic is_signed);
    return (is_signed && x[31]) ? (~x + 32'd1) : x;
  endfunction

endpackage

// File: rtl/ex_stage_div_iter.sv
// Restoring divider, one quotient bit per cycle, with sign fix-up and divide-by-zero result.
// Latency: 1 issue cycle + DIV_ITERS RUN cycles, result valid in DONE.
// Backpressure: holds DONE until ack; busy asserts from the issue cycle through the last RUN cycle.
module ex_stage_div_iter
  import ex_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        signed_op,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  input  logic        ack,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  div_state_e  state_q;
  logic [5:0]  cnt_q;
  logic [31:0] rem_q, quo_q, dvs_q, dvd_q;
  logic        q_neg_q, r_neg_q, div0_q;
  logic [32:0] shifted, diff;

  // Trial subtraction for the current restoring step
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
  end

  // Divider FSM: latch magnitudes, iterate, then wait for the stage to commit
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      case (state_q)
        DIV_IDLE: begin
          if (start) begin
            rem_q   <= '0;
            quo_q   <= mag32(dividend, signed_op);
            dvs_q   <= mag32(divisor, signed_op);
            dvd_q   <= dividend;
            q_neg_q <= signed_op & (dividend[31] ^ divisor[31]);
            r_neg_q <= signed_op & dividend[31];
            div0_q  <= (divisor == 32'd0);
            cnt_q   <= '0;
            state_q <= DIV_RUN;
          end
        end
        DIV_RUN: begin
          if (!diff[32]) begin
            rem_q <= diff[31:0];
            quo_q <= {quo_q[30:0], 1'b1};
          end else begin
            rem_q <= shifted[31:0];
            quo_q <= {quo_q[30:0], 1'b0};
          end
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'(DIV_ITERS - 1)) state_q <= DIV_DONE;
        end
        DIV_DONE: begin
          if (ack) state_q <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  // Status and sign-corrected results; divide-by-zero bypasses the sign fix
  always_comb begin
    busy      = (state_q == DIV_RUN) || ((state_q == DIV_IDLE) && start);
    done      = (state_q == DIV_DONE);
    quotient  = div0_q ? 32'hFFFF_FFFF : (q_neg_q ? (~quo_q + 32'd1) : quo_q);
    remainder = div0_q ? dvd_q         : (r_neg_q ? (~rem_q + 32'd1) : rem_q);
  end

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: pipeline register, ALU, data SRAM request formatting, HI/LO and divider.
// Latency: outputs are combinational from the EX register one cycle after ID presents the bus.
// Backpressure: stall[2] holds (or bubbles when stall[3] runs); divides raise stallreq_for_ex.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [STALL_WD-1:0]     stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_ID_WD-1:0]  ex_to_id,
  output logic                    ex_is_load,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  id_to_ex_t   ex_q, ex_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        commit, bubble;
  logic [31:0] alu_res, mem_addr, ex_result;
  logic [4:0]  sa;
  logic [63:0] prod_s, prod_u;
  logic        div_start, div_busy, div_done;
  logic [31:0] div_quo, div_rem;
  ex_to_mem_t  mem_out;

  assign commit = (stall[STALL_EX] == NO_STOP);
  assign bubble = (stall[STALL_EX] == STOP) && (stall[STALL_MEM] == NO_STOP);

  // Next EX register: bubble, load from ID, or hold
  always_comb begin
    ex_d = ex_q;
    if (bubble)      ex_d = '0;
    else if (commit) ex_d = id_to_ex_bus;
  end

  // EX pipeline register
  always_ff @(posedge clk) begin
    if (rst) ex_q <= '0;
    else     ex_q <= ex_d;
  end

  // ALU; shifts take the amount from src1 and the value from src2
  always_comb begin
    sa      = ex_q.src1[4:0];
    alu_res = '0;
    case (ex_q.alu_op)
      ALU_ADD:  alu_res = ex_q.src1 + ex_q.src2;
      ALU_SUB:  alu_res = ex_q.src1 - ex_q.src2;
      ALU_SLT:  alu_res = {31'd0, $signed(ex_q.src1) < $signed(ex_q.src2)};
      ALU_SLTU: alu_res = {31'd0, ex_q.src1 < ex_q.src2};
      ALU_AND:  alu_res = ex_q.src1 & ex_q.src2;
      ALU_OR:   alu_res = ex_q.src1 | ex_q.src2;
      ALU_XOR:  alu_res = ex_q.src1 ^ ex_q.src2;
      ALU_NOR:  alu_res = ~(ex_q.src1 | ex_q.src2);
      ALU_SLL:  alu_res = ex_q.src2 << sa;
      ALU_SRL:  alu_res = ex_q.src2 >> sa;
      ALU_SRA:  alu_res = $signed(ex_q.src2) >>> sa;
      ALU_LUI:  alu_res = {ex_q.src2[15:0], 16'd0};
      ALU_MFHI: alu_res = hi_q;
      ALU_MFLO: alu_res = lo_q;
      ALU_PASS: alu_res = ex_q.src1;
      default:  alu_res = '0;
    endcase
  end

  // Data SRAM request: byte lanes follow the low address bits, data replicated across lanes
  always_comb begin
    mem_addr        = ex_q.src1 + ex_q.src2;
    ex_result       = ex_q.data_ram_en ? mem_addr : alu_res;
    data_sram_en    = ex_q.data_ram_en;
    data_sram_addr  = mem_addr;
    data_sram_wen   = 4'b0000;
    data_sram_wdata = ex_q.store_data;
    case (ex_q.mem_size)
      MEM_SIZE_BYTE: data_sram_wdata = {4{ex_q.store_data[7:0]}};
      MEM_SIZE_HALF: data_sram_wdata = {2{ex_q.store_data[15:0]}};
      default:       data_sram_wdata = ex_q.store_data;
    endcase
    if (ex_q.data_ram_en && ex_q.mem_we) begin
      case (ex_q.mem_size)
        MEM_SIZE_BYTE: data_sram_wen = 4'b0001 << mem_addr[1:0];
        MEM_SIZE_HALF: data_sram_wen = mem_addr[1] ? 4'b1100 : 4'b0011;
        MEM_SIZE_WORD: data_sram_wen = 4'b1111;
        default:       data_sram_wen = 4'b0000;
      endcase
    end
  end

  assign prod_s = $signed({{32{ex_q.src1[31]}}, ex_q.src1}) * $signed({{32{ex_q.src2[31]}}, ex_q.src2});
  assign prod_u = {32'd0, ex_q.src1} * {32'd0, ex_q.src2};

  assign div_start = (ex_q.md_op == MD_DIV) || (ex_q.md_op == MD_DIVU);

  ex_stage_div_iter u_div (
    .clk       (clk),
    .rst       (rst),
    .start     (div_start),
    .signed_op (ex_q.md_op == MD_DIV),
    .dividend  (ex_q.src1),
    .divisor   (ex_q.src2),
    .ack       (commit),
    .busy      (div_busy),
    .done      (div_done),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

  // HI/LO next state: only an instruction leaving EX may write
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (commit) begin
      case (ex_q.md_op)
        MD_MULT:  {hi_d, lo_d} = prod_s;
        MD_MULTU: {hi_d, lo_d} = prod_u;
        MD_DIV, MD_DIVU: begin
          if (div_done) begin
            hi_d = div_rem;
            lo_d = div_quo;
          end
        end
        MD_MTHI:  hi_d = ex_q.src1;
        MD_MTLO:  lo_d = ex_q.src1;
        default:  ;
      endcase
    end
  end

  // HI/LO registers
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  // Output buses for MEM and ID forwarding
  always_comb begin
    mem_out.pc           = ex_q.pc;
    mem_out.data_ram_en  = ex_q.data_ram_en;
    mem_out.data_ram_wen = data_sram_wen;
    mem_out.sel_rf_res   = ex_q.sel_rf_res;
    mem_out.rf_we        = ex_q.rf_we;
    mem_out.rf_waddr     = ex_q.rf_waddr;
    mem_out.ex_result    = ex_result;
    ex_to_mem_bus        = mem_out;
    ex_to_id             = {ex_q.rf_we, ex_q.rf_waddr, ex_result};
    ex_is_load           = ex_q.sel_rf_res & ex_q.data_ram_en;
    stallreq_for_ex      = div_busy;
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU, stores, HI/LO, divider timing, reset and stall handling.
// Latency: results are sampled 1 ns after the edge that loads the EX register.
// Backpressure: the bench stalls EX and MEM while stallreq_for_ex is high, like the pipeline control.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst;
  logic [5:0]   stall, stall_ovr;
  logic [146:0] id_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_id;
  logic         ex_is_load, data_sram_en, stallreq_for_ex;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  int           checks = 0;
  int           errors = 0;

  always #5 clk = ~clk;

  assign stall = stall_ovr | (stallreq_for_ex ? 6'b001111 : 6'b000000);

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_id        (ex_to_id),
    .ex_is_load      (ex_is_load),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_for_ex (stallreq_for_ex)
  );

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [146:0] mk(input logic [31:0] pc, input logic [4:0] op,
                                      input logic [31:0] s1, input logic [31:0] s2,
                                      input logic [31:0] sd, input logic en, input logic we,
                                      input logic [1:0] sz, input logic sel, input logic rfwe,
                                      input logic [4:0] wa, input logic [2:0] md);
    return {pc, op, s1, s2, sd, en, we, sz, sel, rfwe, wa, md};
  endfunction

  function automatic logic [146:0] alu_i(input logic [4:0] op, input logic [31:0] s1,
                                         input logic [31:0] s2);
    return mk(32'h0040_0000, op, s1, s2, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd2, 3'd0);
  endfunction

  function automatic logic [146:0] md_i(input logic [31:0] pc, input logic [2:0] m,
                                        input logic [31:0] s1, input logic [31:0] s2);
    return mk(pc, 5'd0, s1, s2, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 5'd0, m);
  endfunction

  task automatic step(input logic [146:0] b);
    id_bus = b;
    @(posedge clk);
    #1;
  endtask

  // Count the cycles stallreq stays high from issue, bounded so a stuck divider cannot hang
  task automatic run_div(input string tag);
    int n = 0;
    while (stallreq_for_ex && n < 100) begin
      n++;
      id_bus = '0;
      @(posedge clk);
      #1;
    end
    check({tag, " stall cycles"}, 80'(n), 80'd33);
    check({tag, " done stallreq"}, 80'(stallreq_for_ex), 80'd0);
  endtask

  logic [4:0]  t_op  [0:12] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7,
                                5'd8, 5'd9, 5'd10, 5'd11, 5'd14, 5'd15};
  logic [31:0] t_s1  [0:12] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0, 32'hF0F0F0F0,
                                32'hF0F0F0F0, 32'hF0F0F0F0, 32'd4, 32'd4, 32'd4, 32'd0,
                                32'hCAFEBABE, 32'd7};
  logic [31:0] t_s2  [0:12] = '{32'd7, 32'd1, 32'd1, 32'hFF00FF00, 32'hFF00FF00, 32'hFF00FF00,
                                32'hFF00FF00, 32'd1, 32'h80000000, 32'h80000000, 32'h00001234,
                                32'd0, 32'd9};
  logic [31:0] t_exp [0:12] = '{32'hFFFFFFFE, 32'd1, 32'd0, 32'hF000F000, 32'hFFF0FFF0,
                                32'h0FF00FF0, 32'h000F000F, 32'h10, 32'h08000000, 32'hF8000000,
                                32'h12340000, 32'hCAFEBABE, 32'd0};

  initial begin
    rst = 1'b1; stall_ovr = '0; id_bus = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst mem_bus", 80'(ex_to_mem_bus), 80'd0);
    check("rst to_id", 80'(ex_to_id), 80'd0);
    check("rst stallreq", 80'(stallreq_for_ex), 80'd0);
    check("rst sram_en", 80'(data_sram_en), 80'd0);
    rst = 1'b0;

    // ADD with signed wrap and forwarding bus
    step(mk(32'hBFC00000, 5'd0, 32'h7FFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 5'd5, 3'd0));
    check("add result", 80'(ex_to_mem_bus[31:0]), 80'h80000000);
    check("add to_id", 80'(ex_to_id), 80'h25_8000_0000);
    check("add pc", 80'(ex_to_mem_bus[75:44]), 80'hBFC00000);
    check("add is_load", 80'(ex_is_load), 80'd0);

    // Stores of each size and a load
    step(mk(32'hBFC00004, 5'd0, 32'h1000, 32'd3, 32'h000000AB, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 5'd0, 3'd0));
    check("sb en", 80'(data_sram_en), 80'd1);
    check("sb wen", 80'(data_sram_wen), 80'h8);
    check("sb addr", 80'(data_sram_addr), 80'h1003);
    check("sb wdata", 80'(data_sram_wdata), 80'hABABABAB);
    check("sb bus wen", 80'(ex_to_mem_bus[42:39]), 80'h8);
    check("sb result", 80'(ex_to_mem_bus[31:0]), 80'h1003);
    step(mk(32'hBFC00008, 5'd0, 32'h1000, 32'd2, 32'h1234CDEF, 1'b1, 1'b1, 2'b01, 1'b0, 1'b0, 5'd0, 3'd0));
    check("sh wen", 80'(data_sram_wen), 80'hC);
    check("sh wdata", 80'(data_sram_wdata), 80'hCDEFCDEF);
    step(mk(32'hBFC0000C, 5'd0, 32'h2000, 32'd4, 32'h11223344, 1'b1, 1'b1, 2'b10, 1'b0, 1'b0, 5'd0, 3'd0));
    check("sw wen", 80'(data_sram_wen), 80'hF);
    check("sw wdata", 80'(data_sram_wdata), 80'h11223344);
    step(mk(32'hBFC00010, 5'd0, 32'h2000, 32'd8, 32'd0, 1'b1, 1'b0, 2'b10, 1'b1, 1'b1, 5'd9, 3'd0));
    check("lw wen", 80'(data_sram_wen), 80'h0);
    check("lw is_load", 80'(ex_is_load), 80'd1);
    check("lw addr", 80'(data_sram_addr), 80'h2008);

    // ALU operation table
    for (int i = 0; i < 13; i++) begin
      step(alu_i(t_op[i], t_s1[i], t_s2[i]));
      check($sformatf("alu op%0d", t_op[i]), 80'(ex_to_mem_bus[31:0]), 80'(t_exp[i]));
    end

    // Multiplies followed immediately by HI/LO reads
    step(md_i(32'h100, 3'd1, 32'hFFFFFFFF, 32'd2));
    step(alu_i(5'd12, 32'd0, 32'd0));
    check("mult hi", 80'(ex_to_mem_bus[31:0]), 80'hFFFFFFFF);
    step(alu_i(5'd13, 32'd0, 32'd0));
    check("mult lo", 80'(ex_to_mem_bus[31:0]), 80'hFFFFFFFE);
    step(md_i(32'h104, 3'd2, 32'hFFFFFFFF, 32'd2));
    step(alu_i(5'd12, 32'd0, 32'd0));
    check("multu hi", 80'(ex_to_mem_bus[31:0]), 80'h1);

    // Signed divide -7 / 2
    step(md_i(32'h200, 3'd3, 32'hFFFFFFF9, 32'd2));
    check("div issue stallreq", 80'(stallreq_for_ex), 80'd1);
    run_div("div");
    step(alu_i(5'd12, 32'd0, 32'd0));
    check("div hi", 80'(ex_to_mem_bus[31:0]), 80'hFFFFFFFF);
    check("div idle stallreq", 80'(stallreq_for_ex), 80'd0);
    step(alu_i(5'd13, 32'd0, 32'd0));
    check("div lo", 80'(ex_to_mem_bus[31:0]), 80'hFFFFFFFD);

    // Unsigned divide by zero
    step(md_i(32'h204, 3'd4, 32'h1234, 32'd0));
    run_div("divu0");
    step(alu_i(5'd12, 32'd0, 32'd0));
    check("divu0 hi", 80'(ex_to_mem_bus[31:0]), 80'h1234);
    step(alu_i(5'd13, 32'd0, 32'd0));
    check("divu0 lo", 80'(ex_to_mem_bus[31:0]), 80'hFFFFFFFF);

    // Reset in the middle of a divide
    step(md_i(32'h208, 3'd4, 32'h1234, 32'd0));
    id_bus = '0;
    repeat (10) @(posedge clk);
    #1;
    check("run stallreq", 80'(stallreq_for_ex), 80'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst run stallreq", 80'(stallreq_for_ex), 80'd0);
    check("rst run mem_bus", 80'(ex_to_mem_bus), 80'd0);
    step(alu_i(5'd12, 32'd0, 32'd0));
    check("rst hi", 80'(ex_to_mem_bus[31:0]), 80'd0);
    step(alu_i(5'd13, 32'd0, 32'd0));
    check("rst lo", 80'(ex_to_mem_bus[31:0]), 80'd0);

    // Bubble: EX stopped while MEM runs
    step(alu_i(5'd0, 32'd1, 32'd2));
    check("pre bubble", 80'(ex_to_mem_bus[31:0]), 80'd3);
    stall_ovr = 6'b000100;
    step(alu_i(5'd0, 32'd5, 32'd5));
    check("bubble", 80'(ex_to_mem_bus), 80'd0);
    stall_ovr = '0;

    // Held MTHI must not write HI; it is then squashed by a bubble
    step(md_i(32'h300, 3'd5, 32'hDEADBEEF, 32'd0));
    stall_ovr = 6'b001100;
    step(alu_i(5'd0, 32'd1, 32'd1));
    step(alu_i(5'd0, 32'd1, 32'd1));
    check("hold pc", 80'(ex_to_mem_bus[75:44]), 80'h300);
    stall_ovr = 6'b000100;
    step(alu_i(5'd0, 32'd1, 32'd1));
    check("squash", 80'(ex_to_mem_bus), 80'd0);
    stall_ovr = '0;
    step(alu_i(5'd12, 32'd0, 32'd0));
    check("held mthi hi", 80'(ex_to_mem_bus[31:0]), 80'd0);

    // Committed MTHI / MTLO
    step(md_i(32'h304, 3'd5, 32'hDEADBEEF, 32'd0));
    step(md_i(32'h308, 3'd6, 32'h13579BDF, 32'd0));
    step(alu_i(5'd12, 32'd0, 32'd0));
    check("mthi hi", 80'(ex_to_mem_bus[31:0]), 80'hDEADBEEF);
    step(alu_i(5'd13, 32'd0, 32'd0));
    check("mtlo lo", 80'(ex_to_mem_bus[31:0]), 80'h13579BDF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline, between ID and MEM.
- Registers `id_to_ex_bus` under the stall bus and computes the ALU result.
- Generates data SRAM requests: enable, byte-write-enable, address and store data.
- Owns the HI/LO registers and a 32-iteration restoring divider; raises a stall request while a divide is in flight.
- Produces `ex_to_mem_bus` (76 bits) and the ID forwarding bus.

Parameters:
- ID_TO_EX_WD, 147, width of the input bus (`defines.vh`).
- EX_TO_MEM_WD, 76, width of the output bus (`defines.vh`).
- DIV_ITERS, 32, number of divider iterations.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- stall  in  StallBus  stall vector; stall[2] = EX, stall[3] = MEM; Stop = 1.
- id_to_ex_bus  in  147  fields, MSB first:
  - pc[146:115], alu_op[114:110], src1[109:78], src2[77:46], store_data[45:14]
  - data_ram_en[13], mem_we[12], mem_size[11:10] (00 byte, 01 half, 10 word)
  - sel_rf_res[9], rf_we[8], rf_waddr[7:3], md_op[2:0]
- ex_to_mem_bus  out  76  fields: pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0].
- ex_to_id  out  38  fields: {rf_we, rf_waddr, ex_result}, for forwarding.
- ex_is_load  out  1  = registered sel_rf_res & data_ram_en; used by ID for load-use stall.
- data_sram_en  out  1
- data_sram_wen  out  4
- data_sram_addr  out  32
- data_sram_wdata  out  32
- stallreq_for_ex  out  1  divider busy.

Behaviour:
- Input register:
  - rst → 0.
  - stall[2]=Stop and stall[3]=NoStop → 0 (bubble).
  - stall[2]=NoStop → load id_to_ex_bus.
  - Otherwise hold.
- A zero register is a NOP: no register write, no memory access, md_op none.
- All outputs are combinational from the register, HI/LO and the divider. Under reset every output is 0 and the FSM is IDLE.
- alu_op encoding; shift ops use src1[4:0] as shift amount and src2 as value:
  - 0 ADD, 1 SUB (both wrap, no overflow trap)
  - 2 SLT (signed), 3 SLTU
  - 4 AND, 5 OR, 6 XOR, 7 NOR
  - 8 SLL, 9 SRL, 10 SRA
  - 11 LUI = {src2[15:0], 16'b0}
  - 12 MFHI, 13 MFLO, 14 PASS = src1
  - others → 0.
- Memory access: address = src1 + src2, emitted as both ex_result and data_sram_addr; data_sram_en = data_ram_en.
  - Store byte: wen = 4'b0001 << addr[1:0]; wdata = {4{store_data[7:0]}}.
  - Store half: wen = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{store_data[15:0]}}.
  - Store word: wen = 4'hF; wdata = store_data.
  - Load: wen = 0.
  - Misalignment is not checked.
- data_ram_wen in `ex_to_mem_bus` equals data_sram_wen.
- md_op encoding: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO.
- commit = (stall[2] == NoStop).
- HI/LO: reset 0; written only on a clock edge with commit high.
  - MULT/MULTU: combinational 64-bit product of src1 and src2; {HI,LO} ← product.
  - MTHI: HI ← src1.
  - MTLO: LO ← src1.
  - A following MFHI/MFLO sees the new value with no hazard.
- Divider FSM, states IDLE / RUN / DONE:
  - IDLE with md_op DIV/DIVU: latch operand magnitudes (signed ops use abs values) and record quotient/remainder signs; count ← 0; go to RUN. stallreq = 1.
  - RUN: one restoring shift-subtract step per cycle; stallreq = 1. After DIV_ITERS steps go to DONE.
  - DONE: stallreq = 0; results are sign-fixed.
    - Quotient is negated if the operand signs differ.
    - Remainder takes the sign of the dividend.
    - On commit: HI ← remainder, LO ← quotient, go to IDLE.
    - Without commit (stall held by a later stage) stay in DONE.
  - Total EX occupancy of a divide with no other stalls: 34 cycles (1 issue, 32 RUN, 1 DONE).
  - Divisor 0: HI ← dividend, LO ← 32'hFFFFFFFF, no sign fix, same latency.
  - rst in any state → IDLE, HI/LO ← 0.
  - The FSM cannot restart on the same instruction, because leaving DONE requires commit, which replaces the register.

Decomposition:
- Add to `lib/defines.vh`:
  - ID_TO_EX_WD, EX_TO_MEM_WD
  - ALU_* op codes, MD_* op codes, MEM_SIZE_* codes.
- One sub-module, `div_iter`:
  - Inputs: clk, rst, start, signed_op, dividend, divisor, ack (= commit).
  - Outputs: busy, done, quotient, remainder.
  - Contains the FSM and counter.
- `ex_stage` holds the pipeline register, ALU, store formatting and HI/LO.

Test Plan:
- ADD src1=0x7FFFFFFF, src2=1, rf_we=1, waddr=5 → ex_result=0x80000000; ex_to_id={1,5,0x80000000}; ex_is_load=0.
- SB src1=0x1000, src2=3, store_data=0x000000AB → data_sram_en=1, wen=4'b1000, addr=0x1003, wdata=0xABABABAB.
- MULT src1=0xFFFFFFFF (−1), src2=2, then MFHI, then MFLO → ex_result 0xFFFFFFFF, then 0xFFFFFFFE.
- DIV src1=−7, src2=2 →
  - stallreq high for exactly 33 cycles from issue;
  - DONE cycle stallreq=0;
  - afterwards HI=0xFFFFFFFF (−1), LO=0xFFFFFFFD (−3).
- DIVU by 0 with dividend 0x1234 → HI=0x1234, LO=0xFFFFFFFF after 34 cycles. Repeat with rst pulsed in RUN cycle 10 → FSM IDLE, stallreq=0, HI=LO=0.
- stall[2]=1, stall[3]=0 for one cycle → next ex_to_mem_bus=0 (bubble). stall[2]=stall[3]=1 → register holds; no HI/LO write for the held MTHI.
